// File: rtl/stream_hub_if.sv
// Bundles the SPI packet port and the per-block streams of the stream hub.
// Latency: none, plain wires.
// Backpressure: val/rdy on every stream; master is the hub side, slave is the attached side.
interface stream_hub_if #(
  parameter int N_BLOCKS  = 2,
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 4
);
  logic [ADDR_BITS+DATA_BITS-1:0] spi_recv_msg;
  logic                           spi_recv_val;
  logic                           spi_recv_rdy;
  logic [ADDR_BITS+DATA_BITS-1:0] spi_send_msg;
  logic                           spi_send_val;
  logic                           spi_send_rdy;
  logic [N_BLOCKS*DATA_BITS-1:0]  blk_send_msg;
  logic [N_BLOCKS-1:0]            blk_send_val;
  logic [N_BLOCKS-1:0]            blk_send_rdy;
  logic [N_BLOCKS*DATA_BITS-1:0]  blk_recv_msg;
  logic [N_BLOCKS-1:0]            blk_recv_val;
  logic [N_BLOCKS-1:0]            blk_recv_rdy;

  modport master (
    input  spi_recv_msg, spi_recv_val, output spi_recv_rdy,
    output spi_send_msg, spi_send_val, input  spi_send_rdy,
    output blk_send_msg, blk_send_val, input  blk_send_rdy,
    input  blk_recv_msg, blk_recv_val, output blk_recv_rdy
  );

  modport slave (
    output spi_recv_msg, spi_recv_val, input  spi_recv_rdy,
    input  spi_send_msg, spi_send_val, output spi_send_rdy,
    input  blk_send_msg, blk_send_val, output blk_send_rdy,
    output blk_recv_msg, blk_recv_val, input  blk_recv_rdy
  );
endinterface

// File: rtl/stream_hub.sv
// Routes SPI ingress packets and block output streams to block inputs / SPI egress via a programmable table.
// Latency: zero, every path is combinational; only routes, arbiter pointers and the error count are stored.
// Backpressure: destination rdy passes straight back to the granted source; losers see rdy=0; grants never depend on rdy.
module stream_hub #(
  parameter int N_BLOCKS  = 2,
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  stream_hub_if.master io,
  output logic [7:0]   err_count
);
  localparam int CFG_BITS = $clog2(N_BLOCKS + 2);
  // Requesters: blocks 0..N_BLOCKS-1 plus SPI ingress at index N_BLOCKS.
  // Destinations: block inputs 0..N_BLOCKS-1 plus SPI egress at index N_BLOCKS.
  localparam int NS = N_BLOCKS + 1;
  localparam int PW = $clog2(NS);
  // Address limits carry one spare bit so 2*N_BLOCKS never wraps.
  localparam logic [ADDR_BITS:0]  LIM_N  = (ADDR_BITS+1)'(N_BLOCKS);
  localparam logic [ADDR_BITS:0]  LIM_2N = (ADDR_BITS+1)'(2 * N_BLOCKS);
  localparam logic [CFG_BITS-1:0] RT_SPI = CFG_BITS'(N_BLOCKS);

  logic [CFG_BITS-1:0]  route [N_BLOCKS];
  logic [PW-1:0]        ptr [NS];
  logic [NS-1:0]        req [NS];
  logic [NS-1:0]        gnt_vld;
  logic [PW-1:0]        gnt_idx [NS];
  logic [DATA_BITS-1:0] src_dat [NS];
  logic [NS-1:0]        dest_rdy;
  logic [ADDR_BITS:0]   in_addr;
  logic [DATA_BITS-1:0] in_dat;
  logic                 in_cfg;
  logic                 in_bad;

  assign in_addr  = {1'b0, io.spi_recv_msg[ADDR_BITS+DATA_BITS-1 -: ADDR_BITS]};
  assign in_dat   = io.spi_recv_msg[DATA_BITS-1:0];
  assign in_cfg   = io.spi_recv_val && (in_addr >= LIM_N) && (in_addr < LIM_2N);
  assign in_bad   = io.spi_recv_val && (in_addr >= LIM_2N);
  assign dest_rdy = {io.spi_send_rdy, io.blk_send_rdy};

  // Collect the payload of every requester into one indexable table.
  always_comb begin
    for (int s = 0; s < N_BLOCKS; s++) begin
      src_dat[s] = io.blk_recv_msg[s*DATA_BITS +: DATA_BITS];
    end
    src_dat[N_BLOCKS] = in_dat;
  end

  // Build request vectors per destination; reset suppresses every request.
  always_comb begin
    for (int d = 0; d < NS; d++) begin
      req[d] = '0;
      for (int s = 0; s < N_BLOCKS; s++) begin
        req[d][s] = reset && io.blk_recv_val[s] && (route[s] == CFG_BITS'(d));
      end
      if (d < N_BLOCKS) begin
        req[d][N_BLOCKS] = reset && io.spi_recv_val && (in_addr == (ADDR_BITS+1)'(d));
      end
    end
  end

  // Round-robin pick: first requester at or after ptr, then wrap to the lower indices.
  always_comb begin
    for (int d = 0; d < NS; d++) begin
      gnt_vld[d] = 1'b0;
      gnt_idx[d] = '0;
      for (int s = 0; s < NS; s++) begin
        if (!gnt_vld[d] && (s >= int'(ptr[d])) && req[d][s]) begin
          gnt_vld[d] = 1'b1;
          gnt_idx[d] = PW'(s);
        end
      end
      for (int s = 0; s < NS; s++) begin
        if (!gnt_vld[d] && req[d][s]) begin
          gnt_vld[d] = 1'b1;
          gnt_idx[d] = PW'(s);
        end
      end
    end
  end

  // Steer granted data to destinations and return destination rdy to the grantees.
  always_comb begin
    io.blk_send_val = '0;
    io.blk_send_msg = '0;
    io.spi_send_val = 1'b0;
    io.spi_send_msg = '0;
    io.blk_recv_rdy = '0;
    io.spi_recv_rdy = 1'b0;
    for (int d = 0; d < N_BLOCKS; d++) begin
      if (gnt_vld[d]) begin
        io.blk_send_val[d] = 1'b1;
        for (int s = 0; s < NS; s++) begin
          if (gnt_idx[d] == PW'(s)) begin
            io.blk_send_msg[d*DATA_BITS +: DATA_BITS] = src_dat[s];
          end
        end
      end
    end
    if (gnt_vld[N_BLOCKS]) begin
      io.spi_send_val = 1'b1;
      for (int s = 0; s < N_BLOCKS; s++) begin
        if (gnt_idx[N_BLOCKS] == PW'(s)) begin
          io.spi_send_msg = {ADDR_BITS'(s), src_dat[s]};
        end
      end
    end
    for (int s = 0; s < N_BLOCKS; s++) begin
      if (route[s] > RT_SPI) begin
        // Discard route: always drain the block, data goes nowhere.
        io.blk_recv_rdy[s] = reset;
      end else begin
        for (int d = 0; d < NS; d++) begin
          if (gnt_vld[d] && (gnt_idx[d] == PW'(s))) begin
            io.blk_recv_rdy[s] = dest_rdy[d];
          end
        end
      end
    end
    if (in_cfg || in_bad) begin
      io.spi_recv_rdy = reset;
    end else begin
      for (int d = 0; d < N_BLOCKS; d++) begin
        if (gnt_vld[d] && (gnt_idx[d] == PW'(N_BLOCKS))) begin
          io.spi_recv_rdy = dest_rdy[d];
        end
      end
    end
  end

  // Advance each destination pointer past its grantee whenever a transfer completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < NS; d++) begin
        ptr[d] <= '0;
      end
    end else begin
      for (int d = 0; d < NS; d++) begin
        if (gnt_vld[d] && dest_rdy[d]) begin
          ptr[d] <= (gnt_idx[d] == PW'(NS - 1)) ? '0 : gnt_idx[d] + 1'b1;
        end
      end
    end
  end

  // Routing table writes and saturating bad-address count; new routes apply next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < N_BLOCKS; j++) begin
        route[j] <= RT_SPI;
      end
      err_count <= 8'd0;
    end else begin
      for (int j = 0; j < N_BLOCKS; j++) begin
        if (in_cfg && (in_addr == LIM_N + (ADDR_BITS+1)'(j))) begin
          route[j] <= in_dat[CFG_BITS-1:0];
        end
      end
      if (in_bad && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
endmodule
